conv2d_stream_param: RTL and testbench

- Parametrised streaming 3x3 2-D convolution engine for the NPU datapath.
- Consumes a raster-order pixel stream of an IMG_WIDTH x IMG_HEIGHT frame. Emits one valid-only (no padding) result per output position with x/y coordinates.
- Adds runtime-loadable signed weights, output arithmetic shift, optional ReLU and signed saturation.
- Sits between the pixel source / frame buffer and downstream pooling or activation stages.

---
 rtl/conv2d_stream_param.sv | 219 +++++++++++++++++++++
 tb/tb_conv2d_stream_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_param.sv
// Streaming 3x3 valid-only convolution over a raster pixel stream.
// Window -> multiply -> two-level adder tree -> shift/ReLU/saturate, 4 cycles after accept.
module conv2d_stream_param #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int PIXEL_W    = 8,
  parameter int COEF_W     = 8,
  parameter int OUT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PIXEL_W-1:0]            pixel_in,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  input  logic                          wt_we,
  input  logic [3:0]                    wt_addr,
  input  logic [COEF_W-1:0]             wt_data,
  input  logic [4:0]                    cfg_shift,
  input  logic                          cfg_relu,
  output logic signed [OUT_W-1:0]       result_out,
  output logic                          result_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  result_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] result_y,
  output logic                          busy,
  output logic                          done
);

  localparam int XW    = $clog2(IMG_WIDTH);
  localparam int YW    = $clog2(IMG_HEIGHT);
  localparam int PW    = PIXEL_W + COEF_W + 1;
  localparam int ACC_W = PIXEL_W + COEF_W + 4;
  localparam int MW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [MW-1:0] SAT_MAX_EXT = {{(MW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN_EXT = {{(MW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]    r_flush_cnt;
  logic [XW-1:0] r_cnt_x;
  logic [YW-1:0] r_cnt_y;
  logic [4:0]    r_shift;
  logic          r_relu;

  logic w_accept;
  logic w_last_px;
  logic w_start_ok;

  logic signed [COEF_W-1:0] r_wt [9];
  logic [PIXEL_W-1:0]       r_lb0 [IMG_WIDTH];
  logic [PIXEL_W-1:0]       r_lb1 [IMG_WIDTH];
  logic [PIXEL_W-1:0]       r_win [9];

  logic signed [PW-1:0]    w_prod [9];
  logic signed [PW-1:0]    r_prod [9];
  logic signed [ACC_W-1:0] w_psum [3];
  logic signed [ACC_W-1:0] r_psum [3];
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] r_acc;

  logic signed [ACC_W-1:0] w_sh;
  logic signed [ACC_W-1:0] w_rl;
  logic signed [MW-1:0]    w_ext;
  logic signed [OUT_W-1:0] w_sat;

  logic          r_v1, r_v2, r_v3, r_v4;
  logic [XW-1:0] r_x1, r_x2, r_x3, r_x4;
  logic [YW-1:0] r_y1, r_y2, r_y3, r_y4;

  assign w_accept   = (r_state == S_RUN) && pixel_valid;
  assign w_last_px  = w_accept && (r_cnt_x == XW'(IMG_WIDTH - 1)) && (r_cnt_y == YW'(IMG_HEIGHT - 1));
  assign w_start_ok = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FLUSH holds until the output register has fired, so done follows the last result.
  always_comb begin
    w_state_nxt = r_state;
    pixel_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        pixel_ready = 1'b1;
        if (w_last_px) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_flush_cnt == 3'd4) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_x     <= '0;
      r_cnt_y     <= '0;
      r_flush_cnt <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_cnt_x <= '0;
        r_cnt_y <= '0;
        r_shift <= cfg_shift;
        r_relu  <= cfg_relu;
      end else if (w_accept) begin
        if (r_cnt_x == XW'(IMG_WIDTH - 1)) begin
          r_cnt_x <= '0;
          if (r_cnt_y == YW'(IMG_HEIGHT - 1)) r_cnt_y <= '0;
          else                                r_cnt_y <= r_cnt_y + 1'b1;
        end else begin
          r_cnt_x <= r_cnt_x + 1'b1;
        end
      end
      if (r_state != S_FLUSH) r_flush_cnt <= '0;
      else                    r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 9; k++) r_wt[k] <= '0;
      r_wt[4] <= COEF_W'(1);
    end else if ((r_state == S_IDLE) && wt_we && (wt_addr <= 4'd8)) begin
      r_wt[wt_addr] <= wt_data;
    end
  end

  // Line buffer 0 holds the oldest row; the new column enters on the right of the window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[r_cnt_x] <= r_lb1[r_cnt_x];
      r_lb1[r_cnt_x] <= pixel_in;
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= r_lb0[r_cnt_x];
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= r_lb1[r_cnt_x];
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pixel_in;
    end
  end

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [PW-1:0] v);
    return {{(ACC_W-PW){v[PW-1]}}, v};
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      w_prod[k] = $signed({{(COEF_W+1){1'b0}}, r_win[k]}) *
                  $signed({{(PIXEL_W+1){r_wt[k][COEF_W-1]}}, r_wt[k]});
    end
    for (int unsigned r = 0; r < 3; r++) begin
      w_psum[r] = sext(r_prod[3*r]) + sext(r_prod[3*r+1]) + sext(r_prod[3*r+2]);
    end
    w_acc = r_psum[0] + r_psum[1] + r_psum[2];
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
    for (int unsigned r = 0; r < 3; r++) r_psum[r] <= w_psum[r];
    r_acc <= w_acc;
  end

  always_comb begin
    w_sh  = r_acc >>> r_shift;
    w_rl  = (r_relu && w_sh[ACC_W-1]) ? '0 : w_sh;
    w_ext = {{(MW-ACC_W){w_rl[ACC_W-1]}}, w_rl};
    if (w_ext > SAT_MAX_EXT)      w_sat = SAT_MAX;
    else if (w_ext < SAT_MIN_EXT) w_sat = SAT_MIN;
    else                          w_sat = w_ext[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_v4 <= 1'b0;
      r_x1 <= '0; r_x2 <= '0; r_x3 <= '0; r_x4 <= '0;
      r_y1 <= '0; r_y2 <= '0; r_y3 <= '0; r_y4 <= '0;
      result_valid <= 1'b0;
      result_out   <= '0;
      result_x     <= '0;
      result_y     <= '0;
    end else begin
      r_v1 <= w_accept && (r_cnt_x >= XW'(2)) && (r_cnt_y >= YW'(2));
      r_x1 <= r_cnt_x - XW'(2);
      r_y1 <= r_cnt_y - YW'(2);
      r_v2 <= r_v1; r_x2 <= r_x1; r_y2 <= r_y1;
      r_v3 <= r_v2; r_x3 <= r_x2; r_y3 <= r_y2;
      r_v4 <= r_v3; r_x4 <= r_x3; r_y4 <= r_y3;
      result_valid <= r_v4;
      if (r_v4) begin
        result_out <= w_sat;
        result_x   <= r_x4;
        result_y   <= r_y4;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream_param.sv
// Directed bench for conv2d_stream_param on an 8x6 frame with hand-derived expected results.
module tb_conv2d_stream_param;

  localparam int W = 8;
  localparam int H = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        pixel_in = '0;
  logic              pixel_valid = 1'b0;
  logic              pixel_ready;
  logic              wt_we = 1'b0;
  logic [3:0]        wt_addr = '0;
  logic [7:0]        wt_data = '0;
  logic [4:0]        cfg_shift = '0;
  logic              cfg_relu = 1'b0;
  logic signed [15:0] result_out;
  logic              result_valid;
  logic [2:0]        result_x;
  logic [2:0]        result_y;
  logic              busy;
  logic              done;

  conv2d_stream_param #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(8), .COEF_W(8), .OUT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .result_out(result_out), .result_valid(result_valid),
    .result_x(result_x), .result_y(result_y),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] res_v [64];
  logic [2:0]         res_x [64];
  logic [2:0]         res_y [64];
  int res_n = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int last_drv = 0;

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (res_n == 0) first_cyc = cyc;
      last_cyc = cyc;
      if (res_n < 64) begin
        res_v[res_n] = result_out;
        res_x[res_n] = result_x;
        res_y[res_n] = result_y;
      end
      res_n++;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int mode, input int x, input int y);
    if (mode == 0)      return y * 8 + x;
    else if (mode == 1) return 10 * x;
    else                return 255;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input int k, input int v);
    wt_we = 1'b1; wt_addr = 4'(k); wt_data = 8'(v);
    tick;
    wt_we = 1'b0;
  endtask

  task automatic load_all(input int v);
    for (int k = 0; k < 9; k++) load_w(k, v);
  endtask

  // Config changes after start must not reach the running frame.
  task automatic start_frame(input int sh, input int rl);
    res_n = 0;
    cfg_shift = 5'(sh); cfg_relu = (rl != 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    cfg_shift = 5'd17; cfg_relu = ~cfg_relu;
  endtask

  task automatic send_px(input int lo, input int hi, input int mode, input int gap,
                         input int wt_at, input int start_at);
    for (int i = lo; i <= hi; i++) begin
      if (gap != 0) begin
        while ($urandom_range(1) == 0) begin
          pixel_valid = 1'b0;
          tick;
        end
      end
      pixel_valid = 1'b1;
      pixel_in = 8'(pix(mode, i % W, i / W));
      if (i == wt_at) begin wt_we = 1'b1; wt_addr = 4'd4; wt_data = 8'd100; end
      if (i == start_at) start = 1'b1;
      last_drv = cyc;
      tick;
      wt_we = 1'b0; start = 1'b0;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_done_cycle"}, cyc, last_cyc + 1);
    chk({tag, "_busy_at_done"}, busy, 1);
    tick;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_formula(input string tag, input int kind);
    int rx, ry, e;
    chk({tag, "_count"}, res_n, 24);
    for (int i = 0; i < 24; i++) begin
      rx = i % 6; ry = i / 6;
      e = (kind == 0) ? ((ry + 1) * 8 + rx + 1) : (45 * (8 * ry + rx) + 555);
      chk({tag, "_x"}, res_x[i], rx);
      chk({tag, "_y"}, res_y[i], ry);
      chk({tag, "_val"}, res_v[i], e);
    end
  endtask

  task automatic check_const(input string tag, input int val);
    logic signed [31:0] v;
    bit seen;
    v = val; seen = 1'b0;
    chk({tag, "_count"}, res_n, 24);
    for (int i = 0; i < 24; i++) begin
      if (!seen && res_v[i] !== 16'(val)) begin
        v = res_v[i]; seen = 1'b1;
      end
    end
    chk({tag, "_value"}, v, val);
  endtask

  task automatic const_frame(input string tag, input int mode, input int sh, input int rl,
                             input int wt_at, input int val);
    start_frame(sh, rl);
    send_px(0, W * H - 1, mode, 0, wt_at, -1);
    finish_frame(tag);
    check_const(tag, val);
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_result", result_out, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", pixel_ready, 0);
    chk("rst_x", result_x, 0);
    chk("rst_y", result_y, 0);
    rst = 1'b0;
    tick;

    start_frame(0, 0);
    chk("run_busy", busy, 1);
    chk("run_ready", pixel_ready, 1);
    send_px(0, W * H - 1, 0, 0, -1, -1);
    chk("flush_ready", pixel_ready, 0);
    chk("flush_busy", busy, 1);
    finish_frame("idA");
    check_formula("idA", 0);

    load_w(0, 1);  load_w(1, 0);  load_w(2, -1);
    load_w(3, 2);  load_w(4, 0);  load_w(5, -2);
    load_w(6, 1);  load_w(7, 0);  load_w(8, -1);
    load_w(12, 50); load_w(15, 50);
    const_frame("sob0", 1, 0, 0, -1, -80);
    const_frame("sob_sh2_wtrun", 1, 2, 0, 25, -20);
    const_frame("sob_relu", 1, 0, 1, -1, 0);

    for (int k = 0; k < 9; k++) load_w(k, k + 1);
    res_n = 0;
    pixel_valid = 1'b1; pixel_in = 8'd200;
    repeat (5) tick;
    pixel_valid = 1'b0;
    repeat (6) tick;
    chk("idle_px_results", res_n, 0);
    chk("idle_px_busy", busy, 0);
    start_frame(0, 0);
    send_px(0, W * H - 1, 0, 0, -1, 20);
    pixel_valid = 1'b1; pixel_in = 8'd200;
    finish_frame("k9");
    pixel_valid = 1'b0;
    check_formula("k9", 1);

    start_frame(0, 0);
    send_px(0, W * H - 1, 0, 1, 30, -1);
    finish_frame("k9gap");
    check_formula("k9gap", 1);

    load_all(127);
    const_frame("satpos", 2, 0, 0, -1, 32767);
    const_frame("satpos_sh4", 2, 4, 0, -1, 18216);
    load_all(-128);
    const_frame("satneg", 2, 0, 0, -1, -32768);
    const_frame("satneg_sh5", 2, 5, 0, -1, -9180);
    const_frame("satneg_sh31", 2, 31, 0, -1, -1);

    start_frame(0, 0);
    send_px(0, 30, 2, 0, -1, -1);
    chk("pre_rst_result", result_out, -32768);
    rst = 1'b1;
    #1;
    chk("mid_rst_result", result_out, 0);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", pixel_ready, 0);
    chk("mid_rst_x", result_x, 0);
    chk("mid_rst_y", result_y, 0);
    #2;
    rst = 1'b0;
    tick;

    start_frame(0, 0);
    send_px(0, 2 * W + 2, 0, 0, -1, -1);
    repeat (8) tick;
    chk("lat_count", res_n, 1);
    chk("lat_cycle", first_cyc, last_drv + 5);
    chk("lat_value", res_v[0], 9);
    chk("lat_ready_gap", pixel_ready, 1);
    send_px(2 * W + 3, W * H - 1, 0, 0, -1, -1);
    finish_frame("lat");
    check_formula("lat", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
